mul_multi_param: RTL and testbench

- Parametrised multicycle multiplier for timing-relaxed wide products.
- Operands are registered on accept. A single combinational multiply of the registered operands is constrained as a LATENCY-cycle multicycle path.
- The product register captures the result exactly LATENCY cycles after accept, and done pulses at that point.
- Adds an explicit start/busy/done handshake, signed/unsigned mode, width/latency parameters, synchronous reset and an optional operand-change auto-restart mode.

---
 rtl/mul_multi_param_if.sv | 16 +
 rtl/mul_multi_param.sv | 92 +++++++++
 tb/tb_mul_multi_param.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_multi_param_if.sv
// Operand/result bundle for the multicycle multiplier.
// master drives the request side; slave is the multiplier.
interface mul_multi_param_if #(
  parameter int WIDTH = 64
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] y;

  modport master (output start, signed_mode, a, b, input busy, done, y);
  modport slave  (input start, signed_mode, a, b, output busy, done, y);
endinterface

// File: rtl/mul_multi_param.sv
// Multicycle multiplier: operands registered on accept, one combinational
// multiply sampled LATENCY cycles later (a_r/b_r/sm_r -> y is a multicycle path).
module mul_multi_param #(
  parameter int WIDTH         = 64,
  parameter int LATENCY       = 5,
  parameter int CHANGE_DETECT = 0
) (
  input logic              clk,
  input logic              rst,
  mul_multi_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] CNT_LOAD = 5'(LATENCY - 1);

  if (WIDTH < 2 || WIDTH > 128) begin : g_bad_width
    $error("mul_multi_param: WIDTH %0d outside 2..128", WIDTH);
  end
  if (LATENCY < 1 || LATENCY > 31) begin : g_bad_latency
    $error("mul_multi_param: LATENCY %0d outside 1..31", LATENCY);
  end

  logic [1:0]       state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             sm_r;
  logic [PW-1:0]    y_r;

  logic [PW-1:0]    ext_a, ext_b, prod;
  logic             changed, accept, can_accept;

  // Low PW bits of the extended product are exact for both signednesses.
  always_comb begin
    ext_a = sm_r ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
    ext_b = sm_r ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
    prod  = ext_a * ext_b;
  end

  always_comb begin
    changed    = (bus.a != a_r) | (bus.b != b_r) | (bus.signed_mode != sm_r);
    accept     = (CHANGE_DETECT != 0) ? changed : bus.start;
    can_accept = (state == S_IDLE) || (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sm_r  <= 1'b0;
      y_r   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (can_accept && accept) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            sm_r  <= bus.signed_mode;
            cnt   <= CNT_LOAD;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          // Auto-restart drops the in-flight result; y is left untouched.
          if (CHANGE_DETECT != 0 && changed) begin
            a_r  <= bus.a;
            b_r  <= bus.b;
            sm_r <= bus.signed_mode;
            cnt  <= CNT_LOAD;
          end else if (cnt == 5'd0) begin
            y_r   <= prod;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.y    = y_r;
endmodule

// File: tb/tb_mul_multi_param.sv
// Self-checking bench: directed corners on several parameter sets plus a
// randomized run of the 8-bit/LATENCY=3 instance against a transaction model.
module tb_mul_multi_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  mul_multi_param_if #(.WIDTH(8))  m_if ();
  mul_multi_param_if #(.WIDTH(64)) w_if ();
  mul_multi_param_if #(.WIDTH(8))  b_if ();
  mul_multi_param_if #(.WIDTH(8))  c_if ();
  mul_multi_param_if #(.WIDTH(8))  l_if ();

  mul_multi_param #(.WIDTH(8),  .LATENCY(3), .CHANGE_DETECT(0)) u_main (.clk(clk), .rst(rst), .bus(m_if));
  mul_multi_param #(.WIDTH(64), .LATENCY(5), .CHANGE_DETECT(0)) u_w64  (.clk(clk), .rst(rst), .bus(w_if));
  mul_multi_param #(.WIDTH(8),  .LATENCY(2), .CHANGE_DETECT(0)) u_b2b  (.clk(clk), .rst(rst), .bus(b_if));
  mul_multi_param #(.WIDTH(8),  .LATENCY(4), .CHANGE_DETECT(1)) u_cd   (.clk(clk), .rst(rst), .bus(c_if));
  mul_multi_param #(.WIDTH(8),  .LATENCY(1), .CHANGE_DETECT(0)) u_l1   (.clk(clk), .rst(rst), .bus(l_if));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    int xi, yi;
    xi = sm ? {{24{x[7]}}, x} : {24'd0, x};
    yi = sm ? {{24{y[7]}}, y} : {24'd0, y};
    return 16'(xi * yi);
  endfunction

  // 8-bit, LATENCY=3 single operation with per-cycle checks
  task automatic op_main(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic sm, input logic [15:0] exp, input logic [15:0] y_before);
    m_if.a = x; m_if.b = y; m_if.signed_mode = sm; m_if.start = 1'b1;
    tick;
    m_if.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, 128'(m_if.busy), 128'(1));
      chk({tag, "_hold"}, 128'(m_if.y), 128'(y_before));
      if (i < 2) tick;
    end
    tick;
    chk({tag, "_done"}, 128'(m_if.done), 128'(1));
    chk({tag, "_y"},    128'(m_if.y),    128'(exp));
    tick;
    chk({tag, "_idle"}, 128'(m_if.done), 128'(0));
  endtask

  logic        pend, allow, done_exp;
  int          acc, k;
  logic [15:0] y_exp, p_exp;
  logic        r_s, s_s, sm_s;
  logic [7:0]  a_s, b_s;

  initial begin
    rst = 1'b1;
    m_if.start = 0; m_if.signed_mode = 0; m_if.a = '0; m_if.b = '0;
    w_if.start = 0; w_if.signed_mode = 0; w_if.a = '0; w_if.b = '0;
    b_if.start = 0; b_if.signed_mode = 0; b_if.a = '0; b_if.b = '0;
    c_if.start = 0; c_if.signed_mode = 0; c_if.a = '0; c_if.b = '0;
    l_if.start = 0; l_if.signed_mode = 0; l_if.a = '0; l_if.b = '0;
    tick; tick;
    chk("rst_busy", 128'(m_if.busy), 128'(0));
    chk("rst_done", 128'(m_if.done), 128'(0));
    chk("rst_y",    128'(m_if.y),    128'(0));
    chk("rst_y64",  w_if.y,          128'(0));
    rst = 1'b0;
    tick;

    // 64-bit unsigned then signed most-negative squared
    w_if.a = '1; w_if.b = 64'd2; w_if.signed_mode = 1'b0; w_if.start = 1'b1;
    tick;
    w_if.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("w64_busy", 128'(w_if.busy), 128'(1));
      chk("w64_hold", w_if.y, 128'(0));
      if (i < 4) tick;
    end
    tick;
    chk("w64_done", 128'(w_if.done), 128'(1));
    chk("w64_y", w_if.y, 128'h1_FFFF_FFFF_FFFF_FFFE);
    tick;
    chk("w64_pulse", 128'(w_if.done), 128'(0));
    w_if.a = 64'h8000_0000_0000_0000; w_if.b = 64'h8000_0000_0000_0000;
    w_if.signed_mode = 1'b1; w_if.start = 1'b1;
    tick;
    w_if.start = 1'b0;
    repeat (5) tick;
    chk("w64s_done", 128'(w_if.done), 128'(1));
    chk("w64s_y", w_if.y, 128'h4000_0000_0000_0000_0000_0000_0000_0000);

    // 8-bit signed/unsigned corner products
    op_main("s80", 8'h80, 8'h80, 1'b1, 16'h4000, 16'h0000);
    op_main("sFF", 8'hFF, 8'h02, 1'b1, 16'hFFFE, 16'h4000);
    op_main("uFF", 8'hFF, 8'h02, 1'b0, 16'h01FE, 16'hFFFE);

    // LATENCY=2: held start, back-to-back, mid-RUN operand change ignored
    b_if.a = 8'd3; b_if.b = 8'd4; b_if.start = 1'b1;
    tick;
    chk("b2b_busy1", 128'(b_if.busy), 128'(1));
    b_if.a = 8'd9; b_if.b = 8'd9;
    tick;
    chk("b2b_busy2", 128'(b_if.busy), 128'(1));
    tick;
    chk("b2b_done1", 128'(b_if.done), 128'(1));
    chk("b2b_y12",   128'(b_if.y),    128'(12));
    b_if.a = 8'd5; b_if.b = 8'd6;
    tick;
    chk("b2b_busy3", 128'(b_if.busy), 128'(1));
    chk("b2b_nodone", 128'(b_if.done), 128'(0));
    tick;
    tick;
    chk("b2b_done2", 128'(b_if.done), 128'(1));
    chk("b2b_y30",   128'(b_if.y),    128'(30));
    b_if.start = 1'b0;
    tick;
    chk("b2b_idle", 128'(b_if.busy), 128'(0));
    b_if.a = 8'd2; b_if.b = 8'd2; b_if.start = 1'b1;
    tick;
    b_if.start = 1'b0;
    b_if.a = 8'd7; b_if.b = 8'd7;
    b_if.start = 1'b1;
    tick;
    b_if.start = 1'b0;
    tick;
    chk("pulse_done", 128'(b_if.done), 128'(1));
    chk("pulse_y",    128'(b_if.y),    128'(4));
    tick;
    chk("pulse_nobusy", 128'(b_if.busy), 128'(0));
    chk("pulse_nodone", 128'(b_if.done), 128'(0));

    // Auto-restart: a changes two cycles into RUN
    c_if.a = 8'd7; c_if.b = 8'd10;
    for (int e = 1; e <= 7; e++) begin
      if (e == 3) c_if.a = 8'd9;
      @(posedge clk); #1;
      if (e < 7) begin
        chk("cd_busy", 128'(c_if.busy), 128'(1));
        chk("cd_nodone", 128'(c_if.done), 128'(0));
        chk("cd_hold", 128'(c_if.y), 128'(0));
      end
      if (e == 2) c_if.a = 8'd9;
    end
    chk("cd_done", 128'(c_if.done), 128'(1));
    chk("cd_y90",  128'(c_if.y),    128'(90));
    for (int e = 0; e < 6; e++) begin
      tick;
      chk("cd_steady", 128'({c_if.busy, c_if.done}), 128'(0));
    end
    chk("cd_keep", 128'(c_if.y), 128'(90));

    // LATENCY=1
    l_if.a = 8'd6; l_if.b = 8'd7; l_if.start = 1'b1;
    tick;
    l_if.start = 1'b0;
    chk("l1_busy", 128'(l_if.busy), 128'(1));
    chk("l1_nodone", 128'(l_if.done), 128'(0));
    tick;
    chk("l1_done", 128'(l_if.done), 128'(1));
    chk("l1_nobusy", 128'(l_if.busy), 128'(0));
    chk("l1_y", 128'(l_if.y), 128'(42));

    // Reset mid-RUN, then reset colliding with start, then recovery
    m_if.a = 8'd5; m_if.b = 8'd5; m_if.signed_mode = 1'b0; m_if.start = 1'b1;
    tick;
    m_if.start = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_busy", 128'(m_if.busy), 128'(0));
    chk("mrst_done", 128'(m_if.done), 128'(0));
    chk("mrst_y",    128'(m_if.y),    128'(0));
    for (int e = 0; e < 4; e++) begin
      tick;
      chk("mrst_quiet", 128'({m_if.busy, m_if.done}), 128'(0));
    end
    rst = 1'b1; m_if.start = 1'b1;
    tick;
    rst = 1'b0; m_if.start = 1'b0;
    chk("rst_wins", 128'(m_if.busy), 128'(0));
    op_main("one", 8'd1, 8'd1, 1'b0, 16'd1, 16'd0);

    // Randomized run against the transaction model
    pend = 1'b0; acc = 0; k = 0; y_exp = 16'd1; p_exp = '0;
    for (int i = 0; i < 600; i++) begin
      r_s  = (i == 0) || ($urandom_range(0, 39) == 0);
      s_s  = ($urandom_range(0, 2) != 0);
      sm_s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a_s = 8'h80;
        1:       a_s = 8'hFF;
        default: a_s = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b_s = 8'h80;
        1:       b_s = 8'hFF;
        default: b_s = 8'($urandom);
      endcase
      rst = r_s; m_if.start = s_s; m_if.signed_mode = sm_s; m_if.a = a_s; m_if.b = b_s;
      @(posedge clk);
      k++;
      done_exp = 1'b0;
      if (r_s) begin
        pend = 1'b0;
        y_exp = '0;
      end else begin
        allow = !pend;
        if (pend && k == acc + 3) begin
          y_exp = p_exp;
          pend = 1'b0;
          done_exp = 1'b1;
        end
        if (allow && s_s) begin
          pend = 1'b1;
          acc = k;
          p_exp = ref_mul8(a_s, b_s, sm_s);
        end
      end
      #1;
      chk("rnd_busy", 128'(m_if.busy), 128'(pend));
      chk("rnd_done", 128'(m_if.done), 128'(done_exp));
      chk("rnd_y",    128'(m_if.y),    128'(y_exp));
    end
    rst = 1'b0;
    m_if.start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
